// File: rtl/mem_arbiter_pkg.sv
// Shared types for the Core-side memory arbiter.
//  - ArbState_t : arbitration FSM states
//  - mem_req_t  : one registered downstream request (addr/data/wr_en/bytesel)
package mem_arbiter_pkg;

  typedef logic [19:1] addr_t;
  typedef logic [15:0] data_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_I     = 2'd1,
    GRANT_D_MEM = 2'd2,
    GRANT_D_IO  = 2'd3
  } ArbState_t;

  typedef struct packed {
    addr_t       addr;
    data_t       data;
    logic        wr_en;
    logic [1:0]  bytesel;
  } mem_req_t;

  // Instruction fetches are full-word reads.
  localparam logic [1:0] FetchBytesel = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every bus the arbiter touches: Core instruction bus, Core data bus,
// shared memory bus (q_m_*) and I/O bus (io_m_*).
//  - slave  : arbiter view (requests in from Core, requests out to memory/I/O)
//  - master : environment view (Core plus downstream responders)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Core instruction fetch bus
  addr_t      instr_m_addr;
  logic       instr_m_access;
  logic       instr_m_ack;
  data_t      instr_m_data_in;
  // Core data bus
  addr_t      data_m_addr;
  data_t      data_m_data_out;
  logic       data_m_access;
  logic       data_m_wr_en;
  logic [1:0] data_m_bytesel;
  logic       d_io;
  logic       data_m_ack;
  data_t      data_m_data_in;
  // Shared memory bus
  addr_t      q_m_addr;
  data_t      q_m_data_out;
  logic       q_m_wr_en;
  logic [1:0] q_m_bytesel;
  logic       q_m_access;
  logic       q_m_ack;
  data_t      q_m_data_in;
  // I/O bus
  addr_t      io_m_addr;
  data_t      io_m_data_out;
  logic       io_m_wr_en;
  logic [1:0] io_m_bytesel;
  logic       io_m_access;
  logic       io_m_ack;
  data_t      io_m_data_in;

  modport slave (
    input  instr_m_addr, instr_m_access,
    output instr_m_ack, instr_m_data_in,
    input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    output data_m_ack, data_m_data_in,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    input  q_m_ack, q_m_data_in,
    output io_m_addr, io_m_data_out, io_m_wr_en, io_m_bytesel, io_m_access,
    input  io_m_ack, io_m_data_in
  );

  modport master (
    output instr_m_addr, instr_m_access,
    input  instr_m_ack, instr_m_data_in,
    output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    input  data_m_ack, data_m_data_in,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    output q_m_ack, q_m_data_in,
    input  io_m_addr, io_m_data_out, io_m_wr_en, io_m_bytesel, io_m_access,
    output io_m_ack, io_m_data_in
  );

endinterface

// File: rtl/mem_req_latch.sv
// Holding register for the granted request. Captures req_i when load_i is set
// and holds it otherwise, so downstream request fields stay stable until ack.
//  clk_i   : clock
//  reset_i : synchronous active-high reset, clears the held request
//  load_i  : capture strobe (asserted on the grant cycle)
//  req_i   : request to capture
//  req_o   : held request
module mem_req_latch
  import mem_arbiter_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     load_i,
  input  mem_req_t req_i,
  output mem_req_t req_o
);

  mem_req_t req_d, req_q;

  always_comb begin
    req_d = req_q;
    if (load_i) begin
      req_d = req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Merges the Core instruction and data buses onto one shared memory bus and
// steers d_io data accesses onto the I/O bus. Data has priority, but after
// max_data_run consecutive data grants with a fetch waiting, the fetch wins.
// One transaction in flight; every transaction passes through one IDLE cycle.
//  clk   : clock
//  reset : synchronous active-high reset (abandons any in-flight access)
//  bus   : all Core / memory / I/O bus signals (slave view)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned max_data_run = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned     RunW   = $clog2(max_data_run + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(max_data_run);

  ArbState_t       state_d, state_q;
  logic [RunW-1:0] run_d, run_q;
  logic            load;
  mem_req_t        req_sel;
  mem_req_t        req_held;

  // Arbitration: requests are only sampled in IDLE; GRANT_* waits for the
  // ack of the bus it owns and ignores everything else.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    load    = 1'b0;
    req_sel = '0;
    case (state_q)
      IDLE: begin
        if (bus.data_m_access && !(bus.instr_m_access && (run_q == RunMax))) begin
          state_d         = bus.d_io ? GRANT_D_IO : GRANT_D_MEM;
          load            = 1'b1;
          req_sel.addr    = bus.data_m_addr;
          req_sel.data    = bus.data_m_data_out;
          req_sel.wr_en   = bus.data_m_wr_en;
          req_sel.bytesel = bus.data_m_bytesel;
          // Only data grants that make a fetch wait count toward the run.
          if (!bus.instr_m_access) begin
            run_d = '0;
          end else if (run_q != RunMax) begin
            run_d = run_q + RunW'(1);
          end
        end else if (bus.instr_m_access) begin
          state_d         = GRANT_I;
          load            = 1'b1;
          req_sel.addr    = bus.instr_m_addr;
          req_sel.bytesel = FetchBytesel;
          run_d           = '0;
        end else begin
          run_d = '0;
        end
      end
      GRANT_I: begin
        if (bus.q_m_ack) state_d = IDLE;
      end
      GRANT_D_MEM: begin
        if (bus.q_m_ack) state_d = IDLE;
      end
      GRANT_D_IO: begin
        if (bus.io_m_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  mem_req_latch u_req_latch (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load),
    .req_i   (req_sel),
    .req_o   (req_held)
  );

  // Request fields are shared; only the access strobes pick the destination.
  assign bus.q_m_addr      = req_held.addr;
  assign bus.q_m_data_out  = req_held.data;
  assign bus.q_m_wr_en     = req_held.wr_en;
  assign bus.q_m_bytesel   = req_held.bytesel;
  assign bus.io_m_addr     = req_held.addr;
  assign bus.io_m_data_out = req_held.data;
  assign bus.io_m_wr_en    = req_held.wr_en;
  assign bus.io_m_bytesel  = req_held.bytesel;

  assign bus.q_m_access  = (state_q == GRANT_I) || (state_q == GRANT_D_MEM);
  assign bus.io_m_access = (state_q == GRANT_D_IO);

  // Acks pass through only from the bus that owns the current grant.
  assign bus.instr_m_ack = bus.q_m_ack && (state_q == GRANT_I);
  assign bus.data_m_ack  = (bus.q_m_ack && (state_q == GRANT_D_MEM)) ||
                           (bus.io_m_ack && (state_q == GRANT_D_IO));

  always_comb begin
    bus.instr_m_data_in = '0;
    bus.data_m_data_in  = '0;
    case (state_q)
      GRANT_I:     bus.instr_m_data_in = bus.q_m_data_in;
      GRANT_D_MEM: bus.data_m_data_in  = bus.q_m_data_in;
      GRANT_D_IO:  bus.data_m_data_in  = bus.io_m_data_in;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MaxRun = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.max_data_run(MaxRun)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Core-side request state kept by the bench
  bit         i_pend, d_pend;
  addr_t      i_addr, d_addr;
  data_t      d_wdata;
  logic       d_wr, d_io_v;
  logic [1:0] d_bsel;
  // Model: consecutive data grants taken while a fetch was waiting
  int         streak;

  byte        obs;
  byte        obs_q[$];
  string      exp_order;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic new_instr();
    i_pend = 1'b1;
    i_addr = addr_t'($urandom);
  endtask

  task automatic new_data();
    d_pend  = 1'b1;
    d_addr  = addr_t'($urandom);
    d_wdata = data_t'($urandom);
    d_wr    = 1'($urandom);
    d_io_v  = ($urandom_range(0, 2) == 0);
    d_bsel  = 2'($urandom);
  endtask

  task automatic drive();
    bus.instr_m_access  = i_pend;
    bus.instr_m_addr    = i_addr;
    bus.data_m_access   = d_pend;
    bus.data_m_addr     = d_addr;
    bus.data_m_data_out = d_wdata;
    bus.data_m_wr_en    = d_wr;
    bus.data_m_bytesel  = d_bsel;
    bus.d_io            = d_io_v;
  endtask

  // One arbitration round, entered at posedge+1 with the arbiter in IDLE and
  // the Core requests already driven. Returns at posedge+1 of the next IDLE.
  task automatic txn(input int lat, input data_t rdata, input bit spur, output byte o);
    byte who;
    bit  is_io;
    o = "-";
    if (d_pend && !(i_pend && streak == MaxRun)) begin
      who    = "D";
      streak = i_pend ? ((streak < MaxRun) ? streak + 1 : MaxRun) : 0;
    end else if (i_pend) begin
      who    = "I";
      streak = 0;
    end else begin
      who    = "-";
      streak = 0;
    end
    is_io = (who == "D") && d_io_v;
    @(negedge clk);
    chk("idle_q_access", 32'(bus.q_m_access), 32'(0));
    chk("idle_io_access", 32'(bus.io_m_access), 32'(0));
    @(posedge clk); #1;
    if (who == "-") return;
    for (int k = 0; k <= lat; k++) begin
      if (k == lat) begin
        if (is_io) begin
          bus.io_m_ack = 1'b1; bus.io_m_data_in = rdata;
        end else begin
          bus.q_m_ack = 1'b1; bus.q_m_data_in = rdata;
        end
      end else if (spur) begin
        // Ack on the bus that does not own the grant
        if (is_io) begin
          bus.q_m_ack = 1'b1; bus.q_m_data_in = data_t'($urandom);
        end else begin
          bus.io_m_ack = 1'b1; bus.io_m_data_in = data_t'($urandom);
        end
      end
      @(negedge clk);
      chk("q_access", 32'(bus.q_m_access), 32'(!is_io));
      chk("io_access", 32'(bus.io_m_access), 32'(is_io));
      if (k == 0) begin
        if (who == "I") begin
          chk("fetch_addr", 32'(bus.q_m_addr), 32'(i_addr));
          chk("fetch_wr_en", 32'(bus.q_m_wr_en), 32'(0));
        end else if (is_io) begin
          chk("io_addr", 32'(bus.io_m_addr), 32'(d_addr));
          chk("io_wdata", 32'(bus.io_m_data_out), 32'(d_wdata));
          chk("io_wr_en", 32'(bus.io_m_wr_en), 32'(d_wr));
          chk("io_bytesel", 32'(bus.io_m_bytesel), 32'(d_bsel));
        end else begin
          chk("mem_addr", 32'(bus.q_m_addr), 32'(d_addr));
          chk("mem_wdata", 32'(bus.q_m_data_out), 32'(d_wdata));
          chk("mem_wr_en", 32'(bus.q_m_wr_en), 32'(d_wr));
          chk("mem_bytesel", 32'(bus.q_m_bytesel), 32'(d_bsel));
        end
      end
      if (k == lat) begin
        chk("instr_ack", 32'(bus.instr_m_ack), 32'(who == "I"));
        chk("data_ack", 32'(bus.data_m_ack), 32'(who == "D"));
        o = bus.instr_m_ack ? "I" : (bus.data_m_ack ? "D" : "?");
      end else begin
        chk("early_instr_ack", 32'(bus.instr_m_ack), 32'(0));
        chk("early_data_ack", 32'(bus.data_m_ack), 32'(0));
      end
      if (who == "I") begin
        chk("data_rdata_unsel", 32'(bus.data_m_data_in), 32'(0));
        if (k == lat) chk("instr_rdata", 32'(bus.instr_m_data_in), 32'(rdata));
      end else begin
        chk("instr_rdata_unsel", 32'(bus.instr_m_data_in), 32'(0));
        if (k == lat) chk("data_rdata", 32'(bus.data_m_data_in), 32'(rdata));
      end
      @(posedge clk); #1;
      bus.q_m_ack = 1'b0; bus.q_m_data_in = '0;
      bus.io_m_ack = 1'b0; bus.io_m_data_in = '0;
    end
    if (who == "I") i_pend = 1'b0;
    else d_pend = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0; streak = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wr = 1'b0; d_io_v = 1'b0; d_bsel = '0;
    drive();
    bus.q_m_ack = 1'b0; bus.q_m_data_in = '0;
    bus.io_m_ack = 1'b0; bus.io_m_data_in = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk("rst_q_access", 32'(bus.q_m_access), 32'(0));
    chk("rst_io_access", 32'(bus.io_m_access), 32'(0));
    chk("rst_q_addr", 32'(bus.q_m_addr), 32'(0));
    chk("rst_q_wdata", 32'(bus.q_m_data_out), 32'(0));
    chk("rst_q_wr_en", 32'(bus.q_m_wr_en), 32'(0));
    chk("rst_q_bytesel", 32'(bus.q_m_bytesel), 32'(0));
    chk("rst_instr_ack", 32'(bus.instr_m_ack), 32'(0));
    chk("rst_data_ack", 32'(bus.data_m_ack), 32'(0));
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Lone fetch at 19'h00100, acked after 3 wait cycles with 16'hbeef
    i_pend = 1'b1; i_addr = 19'h00100; drive();
    txn(3, 16'hbeef, 1'b0, obs);
    drive();
    txn(0, 16'h0000, 1'b0, obs);  // idle round: q access must be low again

    // Fetch and memory write arrive together: data first, then fetch
    obs_q.delete();
    i_pend = 1'b1; i_addr = 19'h00abc;
    d_pend = 1'b1; d_addr = 19'h00200; d_wdata = 16'h1234; d_wr = 1'b1;
    d_bsel = 2'b01; d_io_v = 1'b0;
    drive();
    txn(1, 16'h0000, 1'b0, obs); obs_q.push_back(obs);
    drive();
    txn(0, 16'h7777, 1'b0, obs); obs_q.push_back(obs);
    drive();
    exp_order = "DI";
    for (int i = 0; i < 2; i++) chk("pair_order", 32'(obs_q[i]), 32'(exp_order[i]));

    // I/O read at 19'h00020 returning 16'h00a5
    d_pend = 1'b1; d_addr = 19'h00020; d_wdata = 16'h0000; d_wr = 1'b0;
    d_bsel = 2'b11; d_io_v = 1'b1;
    drive();
    txn(2, 16'h00a5, 1'b0, obs);
    drive();

    // Spurious io ack while the fetch owns the memory bus
    i_pend = 1'b1; i_addr = 19'h0f00d; drive();
    txn(2, 16'h4321, 1'b1, obs);
    drive();

    // Reset while a memory write is outstanding, then a late q ack
    d_pend = 1'b1; d_addr = 19'h12345; d_wdata = 16'hcafe; d_wr = 1'b1;
    d_bsel = 2'b10; d_io_v = 1'b0;
    drive();
    @(negedge clk);
    chk("pre_grant_q_access", 32'(bus.q_m_access), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("inflight_q_access", 32'(bus.q_m_access), 32'(1));
    @(posedge clk); #1;
    reset = 1'b1; d_pend = 1'b0; drive();
    @(posedge clk); #1;
    reset = 1'b0; streak = 0;
    bus.q_m_ack = 1'b1; bus.q_m_data_in = 16'h5555;
    @(negedge clk);
    chk("late_ack_data_ack", 32'(bus.data_m_ack), 32'(0));
    chk("late_ack_instr_ack", 32'(bus.instr_m_ack), 32'(0));
    chk("post_rst_q_access", 32'(bus.q_m_access), 32'(0));
    chk("post_rst_io_access", 32'(bus.io_m_access), 32'(0));
    chk("post_rst_q_addr", 32'(bus.q_m_addr), 32'(0));
    chk("post_rst_q_wdata", 32'(bus.q_m_data_out), 32'(0));
    chk("post_rst_q_wr_en", 32'(bus.q_m_wr_en), 32'(0));
    chk("post_rst_q_bytesel", 32'(bus.q_m_bytesel), 32'(0));
    chk("post_rst_data_rdata", 32'(bus.data_m_data_in), 32'(0));
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    bus.q_m_ack = 1'b0; bus.q_m_data_in = '0;
    @(negedge clk);
    chk("post_rst_state_hold", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;

    // Fetch held while data issues six back-to-back requests
    begin
      int n_d;
      int guard;
      obs_q.delete();
      new_instr();
      new_data(); n_d = 1;
      drive();
      guard = 0;
      while (obs_q.size() < 7 && guard < 20) begin
        bit was_i;
        was_i = i_pend;
        txn(int'($urandom_range(0, 2)), data_t'($urandom), 1'b0, obs);
        obs_q.push_back(obs);
        if (was_i && !i_pend) new_instr();
        if (!d_pend && n_d < 6) begin
          new_data(); n_d++;
        end
        drive();
        guard++;
      end
      exp_order = "DDDDIDD";
      for (int i = 0; i < 7; i++) chk("burst_order", 32'(obs_q[i]), 32'(exp_order[i]));
    end

    // Randomized traffic
    for (int t = 0; t < 120; t++) begin
      if (!i_pend && $urandom_range(0, 99) < 60) new_instr();
      if (!d_pend && $urandom_range(0, 99) < 75) new_data();
      drive();
      txn(int'($urandom_range(0, 3)), data_t'($urandom), ($urandom_range(0, 3) == 0), obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
